// File: rtl/zion_rr_hold_reg_arb.sv
// Round-robin arbiter that sequences many producers into one clear/enable holding register.
// A single consumer drains the register with valid/ready; a drain and a load can share one edge.
module zion_rr_hold_reg_arb #(
   parameter int unsigned       NUM_REQ  = 4,
   parameter int unsigned       WIDTH    = 32,
   parameter logic [WIDTH-1:0]  INI_DATA = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            iReq,
   input  logic [NUM_REQ*WIDTH-1:0]      iDat,
   output logic [NUM_REQ-1:0]            oGnt,
   input  logic                          iClr,
   output logic                          oVld,
   output logic [WIDTH-1:0]              oDat,
   input  logic                          iRdy,
   output logic [$clog2(NUM_REQ)-1:0]    oPtr,
   output logic [15:0]                   oXferCnt
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = 16;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   dat_q, dat_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               free_c;
   logic               grant_c;
   logic               found_c;
   logic [PTR_W-1:0]   sel_c;
   logic [PTR_W-1:0]   ptr_nxt_c;
   logic [WIDTH-1:0]   sel_dat_c;
   logic [NUM_REQ-1:0] gnt_c;

   // Priority search from ptr_q upward, then wrap to the low indices.
   always_comb begin
      found_c   = 1'b0;
      sel_c     = '0;
      sel_dat_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found_c && iReq[k] && (k >= 32'(ptr_q))) begin
            found_c   = 1'b1;
            sel_c     = PTR_W'(k);
            sel_dat_c = iDat[k*WIDTH +: WIDTH];
         end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found_c && iReq[k]) begin
            found_c   = 1'b1;
            sel_c     = PTR_W'(k);
            sel_dat_c = iDat[k*WIDTH +: WIDTH];
         end
      end
   end

   // Grant gating; rst term keeps oGnt low while reset is asserted.
   always_comb begin
      free_c    = (state_q == EMPTY) || iRdy;
      grant_c   = rst && free_c && !iClr && found_c;
      ptr_nxt_c = (sel_c == PTR_W'(NUM_REQ - 1)) ? '0 : sel_c + PTR_W'(1);
      gnt_c     = '0;
      if (grant_c) begin
         gnt_c[sel_c] = 1'b1;
      end
   end

   // Next state: clear dominates, then load (possibly with drain), then drain only.
   always_comb begin
      state_d = state_q;
      dat_d   = dat_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (iClr) begin
         state_d = EMPTY;
         dat_d   = INI_DATA;
      end else begin
         if ((state_q == FULL) && iRdy) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (grant_c) begin
            state_d = FULL;
            dat_d   = sel_dat_c;
            ptr_d   = ptr_nxt_c;
         end else if ((state_q == FULL) && iRdy) begin
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         dat_q   <= INI_DATA;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dat_q   <= dat_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign oGnt     = gnt_c;
   assign oVld     = (state_q == FULL);
   assign oDat     = dat_q;
   assign oPtr     = ptr_q;
   assign oXferCnt = cnt_q;

endmodule

// File: tb/tb_zion_rr_hold_reg_arb.sv
// Directed bench for zion_rr_hold_reg_arb with NUM_REQ=4, WIDTH=32, INI_DATA=0.
module tb_zion_rr_hold_reg_arb;

   logic         clk;
   logic         rst;
   logic [3:0]   iReq;
   logic [127:0] iDat;
   logic [3:0]   oGnt;
   logic         iClr;
   logic         oVld;
   logic [31:0]  oDat;
   logic         iRdy;
   logic [1:0]   oPtr;
   logic [15:0]  oXferCnt;

   int checks   = 0;
   int failures = 0;

   zion_rr_hold_reg_arb #(
      .NUM_REQ  (4),
      .WIDTH    (32),
      .INI_DATA ('0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .iReq     (iReq),
      .iDat     (iDat),
      .oGnt     (oGnt),
      .iClr     (iClr),
      .oVld     (oVld),
      .oDat     (oDat),
      .iRdy     (iRdy),
      .oPtr     (oPtr),
      .oXferCnt (oXferCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag, input logic vld, input logic [31:0] dat,
                             input logic [1:0] ptr, input logic [15:0] cnt);
      check({tag, ".vld"}, 32'(oVld), 32'(vld));
      check({tag, ".dat"}, oDat, dat);
      check({tag, ".ptr"}, 32'(oPtr), 32'(ptr));
      check({tag, ".cnt"}, 32'(oXferCnt), 32'(cnt));
   endtask

   // Drive inputs just after an edge, check the combinational grant, then the registered result.
   task automatic cycle(input string tag, input logic [3:0] req, input logic rdy, input logic clr,
                        input logic [3:0] gnt, input logic vld, input logic [31:0] dat,
                        input logic [1:0] ptr, input logic [15:0] cnt);
      iReq = req;
      iRdy = rdy;
      iClr = clr;
      #1;
      check({tag, ".gnt"}, 32'(oGnt), 32'(gnt));
      @(posedge clk);
      #1;
      check_regs(tag, vld, dat, ptr, cnt);
   endtask

   initial begin
      rst  = 1'b0;
      iReq = 4'b1011;
      iRdy = 1'b1;
      iClr = 1'b0;
      iDat = {$urandom, $urandom, $urandom, $urandom};
      #3;
      check("rst.gnt", 32'(oGnt), 32'h0);
      check_regs("rst", 1'b0, 32'h0, 2'd0, 16'd0);

      @(posedge clk);
      #1;
      iReq = 4'b0000;
      iRdy = 1'b0;
      rst  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("idle.gnt", 32'(oGnt), 32'h0);
         check_regs("idle", 1'b0, 32'h0, 2'd0, 16'd0);
      end

      iDat = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      // Fairness: every requester in turn, one transfer per cycle after the first load.
      cycle("rr0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd1, 16'd0);
      cycle("rr1", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 32'hA1, 2'd2, 16'd1);
      cycle("rr2", 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 32'hA2, 2'd3, 16'd2);
      cycle("rr3", 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 32'hA3, 2'd0, 16'd3);
      cycle("rr4", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd1, 16'd4);

      cycle("drain", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'hA0, 2'd1, 16'd5);
      cycle("bp.load", 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 32'hA2, 2'd3, 16'd5);
      for (int i = 0; i < 5; i++) begin
         cycle("bp.hold", 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hA2, 2'd3, 16'd5);
      end
      cycle("bp.rel", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'hA2, 2'd3, 16'd6);

      cycle("wrap0", 4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd1, 16'd7);
      cycle("wrap1", 4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 32'hA1, 2'd2, 16'd8);

      cycle("clr", 4'b1000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd2, 16'd8);
      cycle("clr.after", 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 32'hA3, 2'd0, 16'd8);

      cycle("ar0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd1, 16'd9);
      cycle("ar1", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 32'hA1, 2'd2, 16'd10);
      // Mid-cycle reset must act without a clock edge.
      #2;
      rst = 1'b0;
      #1;
      check("ar.rst.gnt", 32'(oGnt), 32'h0);
      check_regs("ar.rst", 1'b0, 32'h0, 2'd0, 16'd0);
      #1;
      rst = 1'b1;
      #1;
      check("ar.resume.gnt", 32'(oGnt), 32'h1);
      @(posedge clk);
      #1;
      check_regs("ar.resume", 1'b1, 32'hA0, 2'd1, 16'd0);

      // Stream until the transfer counter reaches its maximum, then one more to wrap it.
      repeat (65535) @(posedge clk);
      #1;
      check("cnt.max", 32'(oXferCnt), 32'hFFFF);
      @(posedge clk);
      #1;
      check("cnt.wrap", 32'(oXferCnt), 32'h0);
      check("cnt.vld", 32'(oVld), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
